// File: rtl/reg_file_if.sv
// Operand-read / writeback bus between decode, writeback and the ALU operand-select stage.
// The register file is the slave: it consumes addresses and write data, and sources rd_q/rs_q.
interface reg_file_if #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
);
   logic              en_in;
   logic [AWIDTH-1:0] rd_addr;
   logic [AWIDTH-1:0] rs_addr;
   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic [DWIDTH-1:0] rd_q;
   logic [DWIDTH-1:0] rs_q;
   logic              en_out;

   modport master (
      output en_in, rd_addr, rs_addr, wr_en, wr_addr, wr_data,
      input  rd_q, rs_q, en_out
   );

   modport slave (
      input  en_in, rd_addr, rs_addr, wr_en, wr_addr, wr_data,
      output rd_q, rs_q, en_out
   );
endinterface

// File: rtl/reg_file.sv
// 2**AWIDTH x DWIDTH register file with one write port and a registered dual-operand read.
// Same-cycle writes are forwarded into the read so each read sees the writes up to its own cycle.
module reg_file #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 3
) (
   input  logic      clk,
   input  logic      rst_n,
   reg_file_if.slave bus
);
   localparam int NREGS = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem [NREGS];
   logic [DWIDTH-1:0] rd_next;
   logic [DWIDTH-1:0] rs_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Bypass: a write landing on the addressed register this cycle wins over the stored value.
   always_comb begin
      rd_next = mem[bus.rd_addr];
      rs_next = mem[bus.rs_addr];
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
         rd_next = bus.wr_data;
      end
      if (bus.wr_en && (bus.wr_addr == bus.rs_addr)) begin
         rs_next = bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_q   <= '0;
         bus.rs_q   <= '0;
         bus.en_out <= 1'b0;
      end else begin
         bus.en_out <= bus.en_in;
         if (bus.en_in) begin
            bus.rd_q <= rd_next;
            bus.rs_q <= rs_next;
         end
      end
   end
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus random traffic, checked against an array model
// where each cycle applies its write first and then serves its read.
module tb_reg_file;
   localparam int DW = 16;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   reg_file #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] model [8];
   logic [DW-1:0] exp_rd;
   logic [DW-1:0] exp_rs;
   logic          exp_en;
   int            checks = 0;
   int            errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_en"}, {31'd0, bus.en_out}, {31'd0, exp_en});
      check_eq({tag, "_rd"}, {16'd0, bus.rd_q}, {16'd0, exp_rd});
      check_eq({tag, "_rs"}, {16'd0, bus.rs_q}, {16'd0, exp_rs});
   endtask

   // One clock: drive inputs, let the edge happen, update the model, check 1 time unit later.
   task automatic cycle(input string tag, input logic en, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rs, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd);
      bus.en_in   = en;
      bus.rd_addr = ra;
      bus.rs_addr = rs;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      @(posedge clk);
      if (we) model[wa] = wd;
      if (en) begin
         exp_rd = model[ra];
         exp_rs = model[rs];
      end
      exp_en = en;
      #1;
      check_outputs(tag);
   endtask

   task automatic idle();
      bus.en_in = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   // Assert reset mid-cycle, confirm immediate clear, release at the next falling edge.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) model[i] = '0;
      exp_rd = '0;
      exp_rs = '0;
      exp_en = 1'b0;
      check_outputs(tag);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.en_in = 1'b0; bus.rd_addr = '0; bus.rs_addr = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      exp_rd = '0; exp_rs = '0; exp_en = 1'b0;
      #1;
      check_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset after a write: the write must not survive.
      cycle("rst_wr", 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 16'h1234);
      cycle("rst_rd0", 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0);
      check_eq("rst_pre_val", {16'd0, bus.rd_q}, 32'h1234);
      do_reset("rst_async");
      cycle("rst_rd1", 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0);
      check_eq("rst_post_val", {16'd0, bus.rd_q}, 32'h0000);

      // Basic write / read / hold.
      cycle("bw_w2", 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 16'hA5A5);
      cycle("bw_w5", 1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 16'h0F0F);
      cycle("bw_rd", 1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0);
      check_eq("bw_rd_val", {16'd0, bus.rd_q}, 32'hA5A5);
      check_eq("bw_rs_val", {16'd0, bus.rs_q}, 32'h0F0F);
      cycle("bw_hold", 1'b0, 3'd7, 3'd7, 1'b0, 3'd0, 16'h0);
      check_eq("bw_hold_rd", {16'd0, bus.rd_q}, 32'hA5A5);

      // Bypass on both operands, then on one.
      cycle("bp_w4", 1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 16'h1111);
      cycle("bp_w1", 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 16'h0001);
      cycle("bp_both", 1'b1, 3'd4, 3'd4, 1'b1, 3'd4, 16'h2222);
      check_eq("bp_both_rs", {16'd0, bus.rs_q}, 32'h2222);
      cycle("bp_one", 1'b1, 3'd4, 3'd1, 1'b1, 3'd4, 16'h2222);
      check_eq("bp_one_rs", {16'd0, bus.rs_q}, 32'h0001);

      // Pipelined stream with a write landing in the middle.
      for (int i = 0; i < 4; i++) cycle("ps_pre", 1'b0, 3'd0, 3'd0, 1'b1, 3'(i), 16'(16'h0010 + i));
      cycle("ps_r0", 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
      cycle("ps_r1", 1'b1, 3'd1, 3'd1, 1'b1, 3'd2, 16'hBEEF);
      cycle("ps_r2", 1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0);
      check_eq("ps_beef", {16'd0, bus.rd_q}, 32'hBEEF);
      cycle("ps_r3", 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0);
      cycle("ps_end", 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);

      // Writes only, then a read sweep.
      for (int i = 0; i < 8; i++) cycle("wo_w", 1'b0, 3'(i), 3'(7 - i), 1'b1, 3'(i), 16'(16'h8000 + i));
      for (int i = 0; i < 8; i++) begin
         cycle("wo_rd", 1'b1, 3'(i), 3'(7 - i), 1'b0, 3'd0, 16'h0);
         check_eq("wo_sweep", {16'd0, bus.rd_q}, 32'h8000 + i);
      end

      // Reset in the middle of back-to-back traffic.
      for (int i = 0; i < 3; i++) cycle("rs_bb", 1'b1, 3'(i), 3'(i + 1), 1'b1, 3'(i + 2), 16'(16'hC000 + i));
      bus.en_in = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'hDEAD;
      do_reset("rs_mid");
      for (int i = 0; i < 8; i++) cycle("rs_after", 1'b1, 3'(i), 3'(i), 1'b0, 3'd0, 16'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle("rnd", 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
               1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
         if (i == 200) do_reset("rnd_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
